renkon_sched_linebuf: RTL
=========================

Name: renkon_sched_linebuf

Overview:
- Layer-level scheduler that sequences the padded line-buffer controller for one convolution layer.
- Latches the layer configuration, then issues one line-buffer frame request per (output-channel group, input channel) pair.
- Waits for each frame to finish before issuing the next, and gives the downstream accumulator first/last-input framing.
- Sits between the layer control FSM (req/ack) and the line-buffer controller (buf_req/buf_ack/buf_stop).

Parameters:
- CORE, 8: output channels processed in parallel per frame group; out_ch advances by CORE.
- CHWIDTH, 16: width of the channel counters and totals.
- DELAY, 1: value driven on buf_delay (line-buffer counter tap); legal range 1..8.

Ports:
- clk  in  1  clock
- xrst  in  1  reset; asynchronous, active-high
- req  in  1  layer start pulse; sampled only in S_IDLE
- ack  out  1  high in S_IDLE (ready for req)
- size, kern, stride, pad  in  LWIDTH each  layer geometry; sampled on the req cycle
- total_in  in  CHWIDTH  input channel count
- total_out  in  CHWIDTH  output channel count
- buf_ack  in  1  line-buffer controller idle
- buf_stop  in  1  line-buffer end-of-frame pulse
- buf_req  out  1  frame request pulse to the line buffer
- lb_size, lb_kern, lb_stride, lb_pad  out  LWIDTH each  latched geometry to the line buffer
- buf_delay  out  32  constant DELAY
- in_ch  out  CHWIDTH  current input channel
- out_ch  out  CHWIDTH  base output channel of the current group
- first_in  out  1  current frame has in_ch==0 (accumulator clear)
- last_in  out  1  current frame has in_ch==total_in-1 (bias/activation apply)
- busy  out  1  state != S_IDLE
- done  out  1  one-cycle pulse when the layer completes
- perf_cycles  out  32  optional-feature counter
- perf_frames  out  CHWIDTH  optional-feature counter

Behaviour:
- Reset (async, xrst=1) applies to every register:
  - state=S_IDLE
  - buf_req, done, first_in, last_in, busy = 0
  - in_ch, out_ch, all lb_* and all latched totals = 0
  - ack=1 once reset deasserts
- States:
  - S_IDLE: ack=1. On req, latch geometry and totals, then go to S_LOAD. req while busy is ignored.
  - S_LOAD: one cycle; clear in_ch and out_ch. If total_in==0 or total_out==0, go to S_DONE with no buf_req. Otherwise go to S_REQ.
  - S_REQ: wait for buf_ack=1; in that cycle assert buf_req for exactly one cycle, then go to S_RUN.
  - S_RUN: wait for buf_stop=1, then go to S_NEXT. A buf_stop arriving in any other state is ignored.
  - S_NEXT: one cycle; advance counters:
    - if in_ch<total_in-1, in_ch+1;
    - else in_ch=0 and out_ch+=CORE;
    - if the new out_ch>=total_out, go to S_DONE; otherwise go to S_REQ.
  - S_DONE: done=1 for one cycle, then S_IDLE.
- buf_req is never asserted on two consecutive cycles. A new request is never issued until buf_ack has returned high after buf_stop; waiting on buf_ack in S_REQ covers the line buffer's WAIT re-entry latency.
- first_in and last_in are registered from the S_NEXT/S_LOAD update and held stable from buf_req through buf_stop.
- out_ch addition uses a CHWIDTH+1-bit sum; overflow counts as >=total_out.
- Frame count is total_in × ceil(total_out/CORE).
- lb_* hold their latched values until the next accepted req; input changes mid-layer have no effect.
- Reset mid-frame: return to S_IDLE immediately, with no trailing buf_req or done.

Optional Feature:
- Macro: RENKON_SCHED_PERF_EN.
- Defined:
  - perf_cycles counts clocks with busy=1, cleared on accepted req, saturating at 2^32-1.
  - perf_frames increments on each buf_req, cleared on accepted req.
  - Both hold their values after done until the next accepted req.
- Undefined: both ports are tied to 0 and no counter logic is synthesized.

Test Plan:
- Basic layer: total_in=3, total_out=8, CORE=8, line-buffer model stops 20 cycles after each req -> exactly 3 buf_req; in_ch sequence 0,1,2; out_ch=0 throughout; first_in only on frame 0; last_in only on frame 2; one done pulse.
- Group wrap: total_in=2, total_out=20 -> 6 frames; out_ch sequence 0,0,8,8,16,16; done after the 6th buf_stop; perf_frames=6 with RENKON_SCHED_PERF_EN.
- Zero channels: total_in=0 with req -> no buf_req, done 2 cycles after req, ack high the cycle after done.
- Back-pressure: buf_ack held low 50 cycles after buf_stop -> buf_req delayed until buf_ack=1, never two consecutive buf_req cycles; spurious buf_stop in S_REQ is ignored.
- Config isolation: change size 12->28 and assert req mid-layer -> lb_size stays 12 and req is ignored; after done, a new req latches 28.
- Async reset during S_RUN of frame 1 -> all outputs at reset values within the reset cycle; a subsequent req restarts at in_ch=0, out_ch=0.

Source files
------------

// File: rtl/renkon_sched_linebuf.sv
// rtl/renkon_sched_linebuf.sv - layer scheduler sequencing line-buffer frames per (output group, input channel)
//
// Optional feature macro: RENKON_SCHED_PERF_EN (perf_cycles / perf_frames counters; tied to 0 when undefined)
//
// Ports:
//   clk, xrst                        clock, asynchronous active-high reset
//   req / ack                        layer start pulse / ready (idle) indication
//   size, kern, stride, pad          layer geometry, sampled on the accepted req
//   total_in, total_out              input / output channel counts, sampled on the accepted req
//   buf_ack, buf_stop                line-buffer idle level / end-of-frame pulse
//   buf_req                          one-cycle frame request to the line buffer
//   lb_size, lb_kern, lb_stride, lb_pad  latched geometry presented to the line buffer
//   buf_delay                        constant line-buffer counter tap (DELAY)
//   in_ch, out_ch                    current input channel / base output channel of the group
//   first_in, last_in                accumulator framing for the current frame
//   busy, done                       layer in progress / one-cycle completion pulse
//   perf_cycles, perf_frames         busy-cycle and frame counters
module renkon_sched_linebuf #(
    parameter int CORE    = 8,
    parameter int CHWIDTH = 16,
    parameter int DELAY   = 1,
    parameter int LWIDTH  = 8
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               req,
    output logic               ack,
    input  logic [LWIDTH-1:0]  size,
    input  logic [LWIDTH-1:0]  kern,
    input  logic [LWIDTH-1:0]  stride,
    input  logic [LWIDTH-1:0]  pad,
    input  logic [CHWIDTH-1:0] total_in,
    input  logic [CHWIDTH-1:0] total_out,
    input  logic               buf_ack,
    input  logic               buf_stop,
    output logic               buf_req,
    output logic [LWIDTH-1:0]  lb_size,
    output logic [LWIDTH-1:0]  lb_kern,
    output logic [LWIDTH-1:0]  lb_stride,
    output logic [LWIDTH-1:0]  lb_pad,
    output logic [31:0]        buf_delay,
    output logic [CHWIDTH-1:0] in_ch,
    output logic [CHWIDTH-1:0] out_ch,
    output logic               first_in,
    output logic               last_in,
    output logic               busy,
    output logic               done,
    output logic [31:0]        perf_cycles,
    output logic [CHWIDTH-1:0] perf_frames
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_RUN, S_NEXT, S_DONE} state_t;

    localparam logic [CHWIDTH-1:0] ONE    = CHWIDTH'(1);
    localparam logic [CHWIDTH:0]   CORE_X = (CHWIDTH+1)'(CORE);

    state_t             state, state_nx;
    logic [CHWIDTH-1:0] tot_in_q, tot_out_q;
    logic [CHWIDTH-1:0] tot_in_m1, nx_in;
    logic [CHWIDTH:0]   out_sum;
    logic               in_wrap, layer_end;

    assign buf_delay = 32'(DELAY);

    // Counter advance for S_NEXT. The extra sum bit makes an out_ch overflow
    // compare as past the end of the layer instead of wrapping to a small value.
    assign tot_in_m1 = tot_in_q - ONE;
    assign in_wrap   = !(in_ch < tot_in_m1);
    assign nx_in     = in_wrap ? '0 : in_ch + ONE;
    assign out_sum   = {1'b0, out_ch} + CORE_X;
    assign layer_end = in_wrap && (out_sum >= {1'b0, tot_out_q});

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ack      = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                ack  = 1'b1;
                busy = 1'b0;
                if (req) state_nx = S_LOAD;
            end
            S_LOAD:  state_nx = (tot_in_q == '0 || tot_out_q == '0) ? S_DONE : S_REQ;
            S_REQ:   if (buf_ack) state_nx = S_RUN;
            S_RUN:   if (buf_stop) state_nx = S_NEXT;
            S_NEXT:  state_nx = layer_end ? S_DONE : S_REQ;
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath. buf_req is registered off the S_REQ->S_RUN transition, so it
    // is a clean single-cycle pulse and cannot repeat: the next S_REQ is at
    // least two cycles (S_RUN, S_NEXT) away.
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            buf_req   <= 1'b0;
            lb_size   <= '0;
            lb_kern   <= '0;
            lb_stride <= '0;
            lb_pad    <= '0;
            tot_in_q  <= '0;
            tot_out_q <= '0;
            in_ch     <= '0;
            out_ch    <= '0;
            first_in  <= 1'b0;
            last_in   <= 1'b0;
        end else begin
            buf_req <= 1'b0;
            case (state)
                S_IDLE: if (req) begin
                    lb_size   <= size;
                    lb_kern   <= kern;
                    lb_stride <= stride;
                    lb_pad    <= pad;
                    tot_in_q  <= total_in;
                    tot_out_q <= total_out;
                end
                S_LOAD: begin
                    in_ch    <= '0;
                    out_ch   <= '0;
                    first_in <= 1'b1;
                    last_in  <= (tot_in_q == ONE);
                end
                S_REQ: if (buf_ack) buf_req <= 1'b1;
                S_NEXT: begin
                    in_ch    <= nx_in;
                    if (in_wrap) out_ch <= out_sum[CHWIDTH-1:0];
                    first_in <= in_wrap;
                    last_in  <= (nx_in == tot_in_m1);
                end
                default: ;
            endcase
        end
    end

`ifdef RENKON_SCHED_PERF_EN
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            perf_cycles <= '0;
            perf_frames <= '0;
        end else if (state == S_IDLE && req) begin
            perf_cycles <= '0;
            perf_frames <= '0;
        end else begin
            if (state != S_IDLE && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (buf_req) perf_frames <= perf_frames + ONE;
        end
    end
`else
    assign perf_cycles = '0;
    assign perf_frames = '0;
`endif

endmodule
